ctrl_pipe_unit: RTL and testbench

Pipelined control unit for the five-stage RV32I core: decodes control bits in ID and carries them through registered ID/EX, EX/MEM and MEM/WB control stages. It inserts bubbles on load-use hazards and branch flushes, freezes on memory stalls, and drains then halts the pipeline on a halting `ecall`. It also counts retired instructions. It sits beside the datapath pipeline registers; every `ex_*`, `mem_*` and `wb_*` output is that stage's registered control.

---
 rtl/ctrl_pipe_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control path of a five-stage RV32I pipeline.
// ID decodes the control bits, and registered ID/EX, EX/MEM and MEM/WB
// stages carry them forward. Bubbles are inserted on load-use hazards,
// branch flushes and while draining. All stages freeze on a memory stall.
// A halting ecall drains the pipe and then halts it. Retired non-bubble
// instructions are counted.
module ctrl_pipe_unit #(
  parameter int XLEN      = 32,
  parameter int HALT_CODE = 10,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          id_inst,
  input  logic                 id_valid,
  input  logic                 load_use_hazard,
  input  logic                 flush,
  input  logic                 mem_stall,
  input  logic [XLEN-1:0]      id_x17,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_jal,
  output logic                 ex_jalr,
  output logic [1:0]           ex_alu_op,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic                 wb_pc_to_reg,
  output logic                 fetch_stop,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [XLEN-1:0] HALT_VAL = XLEN'(HALT_CODE);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       halt;
    logic       alu_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
  } idex_t;

  typedef struct packed {
    logic valid;
    logic halt;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic pc_to_reg;
  } exmem_t;

  typedef struct packed {
    logic valid;
    logic halt;
    logic reg_write;
    logic mem_to_reg;
    logic pc_to_reg;
  } memwb_t;

  state_t state_r, state_next_s;
  idex_t  dec_s, idex_r;
  exmem_t exmem_r;
  memwb_t memwb_r;
  logic   capture_s;

  // Decode the ID instruction into stage controls; anything unknown is a bubble.
  always_comb begin
    dec_s = '{default: 1'b0};
    if (id_valid) begin
      case (id_inst[6:0])
        OP_LOAD: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1; dec_s.mem_read = 1'b1;
          dec_s.reg_write = 1'b1; dec_s.mem_to_reg = 1'b1;
        end
        OP_STORE: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1; dec_s.mem_write = 1'b1;
        end
        OP_BRANCH: begin
          dec_s.valid = 1'b1; dec_s.branch = 1'b1; dec_s.alu_op = 2'b01;
        end
        OP_ECALL: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1;
          dec_s.halt = (id_x17 == HALT_VAL);
        end
        OP_ARITH: begin
          dec_s.valid = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = 2'b10;
        end
        OP_ARITHI: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1;
          dec_s.alu_op = 2'b10;
        end
        OP_JAL: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1; dec_s.jal = 1'b1;
          dec_s.reg_write = 1'b1; dec_s.pc_to_reg = 1'b1;
        end
        OP_JALR: begin
          dec_s.valid = 1'b1; dec_s.alu_src = 1'b1; dec_s.jalr = 1'b1;
          dec_s.reg_write = 1'b1; dec_s.pc_to_reg = 1'b1;
        end
        default: dec_s = '{default: 1'b0};
      endcase
    end else begin
      dec_s = '{default: 1'b0};
    end
  end

  // The ID instruction really enters ID/EX only in RUN with no stall, flush or hazard.
  always_comb begin
    capture_s = (state_r == ST_RUN) && !mem_stall && !flush && !load_use_hazard;
  end

  // Next-state logic: start draining on a captured halt, halt once it leaves WB.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (capture_s && dec_s.halt) state_next_s = ST_DRAIN;
        else                          state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (memwb_r.halt && !mem_stall) state_next_s = ST_HALTED;
        else                            state_next_s = ST_DRAIN;
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_RUN;
    else          state_r <= state_next_s;
  end

  // Stage registers: hold on stall, flush everything when halted, else advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_r  <= '{default: 1'b0};
      exmem_r <= '{default: 1'b0};
      memwb_r <= '{default: 1'b0};
    end else if (mem_stall) begin
      idex_r  <= idex_r;
      exmem_r <= exmem_r;
      memwb_r <= memwb_r;
    end else if (state_r == ST_HALTED) begin
      idex_r  <= '{default: 1'b0};
      exmem_r <= '{default: 1'b0};
      memwb_r <= '{default: 1'b0};
    end else begin
      if (capture_s) idex_r <= dec_s;
      else           idex_r <= '{default: 1'b0};
      exmem_r <= '{valid: idex_r.valid, halt: idex_r.halt,
                   mem_read: idex_r.mem_read, mem_write: idex_r.mem_write,
                   reg_write: idex_r.reg_write, mem_to_reg: idex_r.mem_to_reg,
                   pc_to_reg: idex_r.pc_to_reg};
      memwb_r <= '{valid: exmem_r.valid, halt: exmem_r.halt,
                   reg_write: exmem_r.reg_write, mem_to_reg: exmem_r.mem_to_reg,
                   pc_to_reg: exmem_r.pc_to_reg};
    end
  end

  // Retired counter: one per real instruction leaving WB; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      retired <= {CNT_WIDTH{1'b0}};
    else if (memwb_r.valid && !mem_stall) retired <= retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else                               retired <= retired;
  end

  assign ex_alu_src    = idex_r.alu_src;
  assign ex_branch     = idex_r.branch;
  assign ex_jal        = idex_r.jal;
  assign ex_jalr       = idex_r.jalr;
  assign ex_alu_op     = idex_r.alu_op;
  assign mem_mem_read  = exmem_r.mem_read;
  assign mem_mem_write = exmem_r.mem_write;
  assign wb_reg_write  = memwb_r.reg_write;
  assign wb_mem_to_reg = memwb_r.mem_to_reg;
  assign wb_pc_to_reg  = memwb_r.pc_to_reg;
  assign fetch_stop    = (state_r != ST_RUN);
  assign is_halted     = (memwb_r.halt && memwb_r.valid) || (state_r == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed testbench for ctrl_pipe_unit. Each task owns one scenario and
// compares outputs against hand-computed values; cycle N is the interval
// after the N-th rising edge following the scenario start.
module tb_ctrl_pipe_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] id_inst = 32'd0;
  logic        id_valid = 1'b0, load_use_hazard = 1'b0, flush = 1'b0, mem_stall = 1'b0;
  logic [31:0] id_x17 = 32'd0;
  logic        ex_alu_src, ex_branch, ex_jal, ex_jalr;
  logic [1:0]  ex_alu_op;
  logic        mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg;
  logic        fetch_stop, is_halted;
  logic [31:0] retired;
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0050A223;
  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  ctrl_pipe_unit dut (
    .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .id_valid(id_valid),
    .load_use_hazard(load_use_hazard), .flush(flush), .mem_stall(mem_stall),
    .id_x17(id_x17), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_alu_op(ex_alu_op),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_pc_to_reg(wb_pc_to_reg), .fetch_stop(fetch_stop),
    .is_halted(is_halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] inst, input logic v, input logic luh,
                       input logic fl, input logic st, input logic [31:0] x17);
    id_inst = inst; id_valid = v; load_use_hazard = luh; flush = fl;
    mem_stall = st; id_x17 = x17;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_alu_op, mem_mem_read, mem_mem_write,
         wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, fetch_stop, is_halted} !== 13'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got controls nonzero, want all 0");
    end
    n_checks++;
    if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    do_reset();
  endtask

  task automatic test_load();
    do_reset();
    drive(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c1
    n_checks++;
    if (ex_alu_src !== 1'b1 || ex_alu_op !== 2'b00) begin
      n_fail++; $display("FAIL lw_ex: got alu_src=%0b alu_op=%0b want 1/00", ex_alu_src, ex_alu_op);
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c2
    n_checks++;
    if (mem_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_mem_read: got %0b want 1", mem_mem_read); end
    tick(); // c3
    n_checks++;
    if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || retired !== 32'd0) begin
      n_fail++; $display("FAIL lw_wb: got rw=%0b m2r=%0b ret=%0d want 1 1 0", wb_reg_write, wb_mem_to_reg, retired);
    end
    tick(); // c4
    n_checks++;
    if (retired !== 32'd1 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL lw_retired: got ret=%0d rw=%0b want 1 0", retired, wb_reg_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(I_SW, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); // c1
    n_checks++;
    if ({ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_alu_op} !== 6'd0) begin
      n_fail++; $display("FAIL luh_bubble: got ex alu_src=%0b alu_op=%0b want 0", ex_alu_src, ex_alu_op);
    end
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c2
    n_checks++;
    if (ex_alu_src !== 1'b1 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL luh_replay: got alu_src=%0b rw=%0b want 1 0", ex_alu_src, wb_reg_write);
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c3
    n_checks++;
    if (mem_mem_write !== 1'b1 || mem_mem_read !== 1'b0) begin
      n_fail++; $display("FAIL sw_mem_write: got w=%0b r=%0b want 1 0", mem_mem_write, mem_mem_read);
    end
    tick(); // c4
    n_checks++;
    if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL sw_wb_rw: got %0b want 0", wb_reg_write); end
    tick(); // c5
    n_checks++;
    if (retired !== 32'd1) begin n_fail++; $display("FAIL sw_retired: got %0d want 1", retired); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c1
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c2: lw in MEM, add in EX
    n_checks++;
    if (ex_alu_op !== 2'b10 || ex_alu_src !== 1'b0) begin
      n_fail++; $display("FAIL add_ex: got alu_op=%0b alu_src=%0b want 10 0", ex_alu_op, ex_alu_src);
    end
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); // c3..c5 held
      n_checks++;
      if (mem_mem_read !== 1'b1 || ex_alu_op !== 2'b10 || wb_reg_write !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got rd=%0b op=%0b rw=%0b want 1 10 0", i, mem_mem_read, ex_alu_op, wb_reg_write);
      end
      if (i == 1) drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      if (i == 2) drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    // stall was high for cycles c2..c4; c5 is the first non-stalled cycle
    tick(); // c6
    n_checks++;
    if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || mem_mem_read !== 1'b0 || retired !== 32'd0) begin
      n_fail++; $display("FAIL stall_lw_wb: got rw=%0b m2r=%0b rd=%0b ret=%0d want 1 1 0 0", wb_reg_write, wb_mem_to_reg, mem_mem_read, retired);
    end
    tick(); // c7
    n_checks++;
    if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b0 || retired !== 32'd1) begin
      n_fail++; $display("FAIL stall_add_wb: got rw=%0b m2r=%0b ret=%0d want 1 0 1", wb_reg_write, wb_mem_to_reg, retired);
    end
    tick(); // c8
    n_checks++;
    if (retired !== 32'd2) begin n_fail++; $display("FAIL stall_retired: got %0d want 2", retired); end
  endtask

  task automatic test_flush_ecall();
    do_reset();
    drive(I_ECALL, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10);
    tick(); // c1
    n_checks++;
    if (fetch_stop !== 1'b0 || ex_alu_src !== 1'b0) begin
      n_fail++; $display("FAIL flush_ecall: got fetch_stop=%0b alu_src=%0b want 0 0", fetch_stop, ex_alu_src);
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); tick(); tick(); // c4
    n_checks++;
    if (fetch_stop !== 1'b0 || is_halted !== 1'b0 || retired !== 32'd0) begin
      n_fail++; $display("FAIL flush_ecall_late: got fs=%0b h=%0b ret=%0d want 0 0 0", fetch_stop, is_halted, retired);
    end
  endtask

  task automatic test_flush_and_hazard();
    do_reset();
    drive(I_LW, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    tick(); // c1
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (ex_alu_src !== 1'b0 || ex_alu_op !== 2'b00) begin
      n_fail++; $display("FAIL both_bubble: got alu_src=%0b op=%0b want 0 00", ex_alu_src, ex_alu_op);
    end
    tick(); // c2
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (ex_alu_op !== 2'b10 || mem_mem_read !== 1'b0) begin
      n_fail++; $display("FAIL both_single: got op=%0b rd=%0b want 10 0", ex_alu_op, mem_mem_read);
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(I_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10);
    tick(); // c1
    n_checks++;
    if (fetch_stop !== 1'b1 || ex_alu_src !== 1'b1 || is_halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_c1: got fs=%0b alu_src=%0b h=%0b want 1 1 0", fetch_stop, ex_alu_src, is_halted);
    end
    drive(I_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); // c2
    n_checks++;
    if (ex_alu_op !== 2'b00 || is_halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_younger: got op=%0b h=%0b want 00 0", ex_alu_op, is_halted);
    end
    tick(); // c3
    n_checks++;
    if (is_halted !== 1'b1 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL halt_c3: got h=%0b rw=%0b want 1 0", is_halted, wb_reg_write);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); // c4..c7
      n_checks++;
      if (is_halted !== 1'b1 || fetch_stop !== 1'b1 || retired !== 32'd1 || wb_reg_write !== 1'b0) begin
        n_fail++; $display("FAIL halt_sticky%0d: got h=%0b fs=%0b ret=%0d rw=%0b want 1 1 1 0", i, is_halted, fetch_stop, retired, wb_reg_write);
      end
    end
  endtask

  task automatic test_drain_stall();
    do_reset();
    drive(I_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10);
    tick(); // c1
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(); // c2: stall held ecall in EX
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (fetch_stop !== 1'b1 || ex_alu_src !== 1'b1) begin
      n_fail++; $display("FAIL drain_stall_c2: got fs=%0b alu_src=%0b want 1 1", fetch_stop, ex_alu_src);
    end
    tick(); // c3
    n_checks++;
    if (is_halted !== 1'b0) begin n_fail++; $display("FAIL drain_stall_c3: got %0b want 0", is_halted); end
    tick(); // c4
    n_checks++;
    if (is_halted !== 1'b1) begin n_fail++; $display("FAIL drain_stall_c4: got %0b want 1", is_halted); end
  endtask

  task automatic test_ecall_nohalt();
    do_reset();
    drive(I_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5);
    tick(); // c1
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (fetch_stop !== 1'b0 || ex_alu_src !== 1'b1) begin
      n_fail++; $display("FAIL ecall5_c1: got fs=%0b alu_src=%0b want 0 1", fetch_stop, ex_alu_src);
    end
    tick(); tick(); // c3
    n_checks++;
    if (wb_reg_write !== 1'b0 || is_halted !== 1'b0) begin
      n_fail++; $display("FAIL ecall5_wb: got rw=%0b h=%0b want 0 0", wb_reg_write, is_halted);
    end
    tick(); // c4
    n_checks++;
    if (retired !== 32'd1 || fetch_stop !== 1'b0) begin
      n_fail++; $display("FAIL ecall5_ret: got ret=%0d fs=%0b want 1 0", retired, fetch_stop);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c1
    n_checks++;
    if (ex_branch !== 1'b1 || ex_alu_op !== 2'b01 || ex_alu_src !== 1'b0) begin
      n_fail++; $display("FAIL beq_ex: got br=%0b op=%0b src=%0b want 1 01 0", ex_branch, ex_alu_op, ex_alu_src);
    end
    drive(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c2
    n_checks++;
    if (ex_jal !== 1'b1 || ex_alu_src !== 1'b1 || ex_branch !== 1'b0) begin
      n_fail++; $display("FAIL jal_ex: got jal=%0b src=%0b br=%0b want 1 1 0", ex_jal, ex_alu_src, ex_branch);
    end
    drive(I_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c3
    n_checks++;
    if (ex_jalr !== 1'b1 || ex_jal !== 1'b0 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL jalr_ex: got jalr=%0b jal=%0b rw=%0b want 1 0 0", ex_jalr, ex_jal, wb_reg_write);
    end
    drive(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c4
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if ({ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_alu_op} !== 6'd0 ||
        wb_pc_to_reg !== 1'b1 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL bad_op_and_jal_wb: got src=%0b pc2r=%0b rw=%0b want 0 1 1", ex_alu_src, wb_pc_to_reg, wb_reg_write);
    end
    tick(); tick(); // c6
    n_checks++;
    if (retired !== 32'd3) begin n_fail++; $display("FAIL b2b_retired: got %0d want 3", retired); end
    tick(); // c7
    n_checks++;
    if (retired !== 32'd3) begin n_fail++; $display("FAIL bad_op_retired: got %0d want 3", retired); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); // c1
    drive(I_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10);
    tick(); // c2
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); tick(); // c4: ecall in WB, still draining
    n_checks++;
    if (retired !== 32'd1 || fetch_stop !== 1'b1 || is_halted !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got ret=%0d fs=%0b h=%0b want 1 1 1", retired, fetch_stop, is_halted);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (fetch_stop !== 1'b0 || is_halted !== 1'b0 || retired !== 32'd0 ||
        {ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg} !== 8'd0) begin
      n_fail++; $display("FAIL reset_drain: got fs=%0b h=%0b ret=%0d want 0 0 0", fetch_stop, is_halted, retired);
    end
    #3;
    reset_n = 1'b1;
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    n_checks++;
    if (ex_alu_op !== 2'b10 || fetch_stop !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_run: got op=%0b fs=%0b want 10 0", ex_alu_op, fetch_stop);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_use();
    test_stall();
    test_flush_ecall();
    test_flush_and_hazard();
    test_halt();
    test_drain_stall();
    test_ecall_nohalt();
    test_back_to_back();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
